// File: rtl/sfifo_drain_pkg.sv
// Shared types and constants for the FIFO burst drainer and its skid buffer.
package sfifo_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/sfifo_drain_if.sv
// FIFO read side plus output stream of the drainer, bundled as one interface.
interface sfifo_drain_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 3
);
  logic [DEPTH_BITS:0] fifo_count;
  logic                fifo_empty;
  logic [WIDTH-1:0]    fifo_dout;
  logic                fifo_rd;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic                out_last;
  logic                out_ready;

  modport master (
    input  fifo_count, fifo_empty, fifo_dout, out_ready,
    output fifo_rd, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_count, fifo_empty, fifo_dout, out_ready,
    input  fifo_rd, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sfifo_drain_skid.sv
// Two-entry registered valid/ready buffer; head entry drives the output directly.
// Caller must not push at full occupancy unless the head is popped the same cycle.
module sdrain_skid
  import sfifo_drain_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy,
  output logic [1:0]   occ
);

  localparam logic [1:0] OCC_FULL = 2'(SKID_DEPTH);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  assign pop     = (occ_q != 2'd0) && out_rdy;
  assign out_vld = (occ_q != 2'd0);
  assign out_dat = head_q;
  assign occ     = occ_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case (occ_q)
      2'd0: begin
        if (push_vld) begin
          head_d = push_dat;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_vld && pop) begin
          head_d = push_dat;
        end else if (push_vld) begin
          tail_d = push_dat;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        // Full: the tail slides into the head on every pop.
        if (pop) begin
          head_d = tail_q;
          if (push_vld) tail_d = push_dat;
          else          occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/sfifo_drain.sv
// Drains a synchronous FIFO in snapshot-length bursts once a threshold, timeout or flush fires.
// Words leave through a 2-entry skid buffer, tagged with a last-of-burst flag.
module sfifo_drain
  import sfifo_drain_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 3,
  parameter int TMO_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  sfifo_drain_if.master       bus,
  input  logic [DEPTH_BITS:0] thresh,
  input  logic [TMO_BITS-1:0] tmo,
  input  logic                flush,
  output logic                busy
);

  localparam logic [DEPTH_BITS:0]  CNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [TMO_BITS-1:0]  TMO_ONE  = {{(TMO_BITS-1){1'b0}}, 1'b1};
  localparam logic [1:0]           OCC_FULL = 2'(SKID_DEPTH);

  state_e              state_q, state_d;
  logic [TMO_BITS-1:0] timer_q, timer_d;
  logic [DEPTH_BITS:0] remain_q, remain_d;
  logic [DEPTH_BITS:0] thr_eff;
  logic [1:0]          occ;
  logic                pop_rd;

  // A zero threshold behaves as one so a single word is enough to start.
  assign thr_eff = (thresh == '0) ? CNT_ONE : thresh;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    remain_d = remain_q;
    pop_rd   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.fifo_empty) begin
          state_d = ST_WAIT;
          timer_d = tmo;
        end
      end
      ST_WAIT: begin
        if ((bus.fifo_count >= thr_eff) || (timer_q == '0) || flush) begin
          state_d  = ST_BURST;
          remain_d = bus.fifo_count;
        end else begin
          timer_d = timer_q - TMO_ONE;
        end
      end
      ST_BURST: begin
        pop_rd = (remain_q != '0) && !bus.fifo_empty &&
                 ((occ < OCC_FULL) || bus.out_ready);
        if (remain_q == '0) begin
          state_d = ST_IDLE;
        end else if (pop_rd) begin
          remain_d = remain_q - CNT_ONE;
          if (remain_q == CNT_ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      remain_q <= remain_d;
    end
  end

  sdrain_skid #(.W(WIDTH + 1)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push_vld (pop_rd),
    .push_dat ({(remain_q == CNT_ONE), bus.fifo_dout}),
    .out_vld  (bus.out_valid),
    .out_dat  ({bus.out_last, bus.out_data}),
    .out_rdy  (bus.out_ready),
    .occ      (occ)
  );

  assign bus.fifo_rd = pop_rd;
  assign busy        = (state_q != ST_IDLE) || (occ != 2'd0);

endmodule

// File: tb/tb_sfifo_drain.sv
// Directed bench for sfifo_drain: behavioural FIFO feeding the DUT, output scoreboard per burst.
module tb_sfifo_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] thresh;
  logic [7:0] tmo;
  logic       flush;
  logic       busy;

  sfifo_drain_if #(.WIDTH(16), .DEPTH_BITS(3)) bus ();

  sfifo_drain #(.WIDTH(16), .DEPTH_BITS(3), .TMO_BITS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .thresh (thresh),
    .tmo    (tmo),
    .flush  (flush),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] fq[$];
  logic [16:0] got[$];
  logic [16:0] ex[$];
  bit          rd_log[$];
  bit          acc_log[$];
  bit          busy_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc_n;
  int          rdy_mode;
  int          occ_m;
  int          occ_max;
  bit          rd_full;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] m = '0;
    for (int i = 0; i < q.size() && i < 32; i++) m[i] = q[i];
    return m;
  endfunction

  task automatic upd();
    bus.fifo_count = 4'(fq.size());
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() != 0) ? fq[0] : 16'h0;
  endtask

  task automatic fwr(input logic [15:0] d);
    fq.push_back(d);
    upd();
  endtask

  task automatic clr();
    got.delete(); ex.delete(); rd_log.delete(); acc_log.delete(); busy_log.delete();
    cyc_n = 0; occ_max = 0; rd_full = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample just before the rising edge, update FIFO after it.
  task automatic tick();
    bit rd, acc;
    case (rdy_mode)
      1:       bus.out_ready = (cyc_n % 3 == 0);
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
    #3;
    rd  = bus.fifo_rd;
    acc = bus.out_valid && bus.out_ready;
    if (rd && occ_m == 2 && !bus.out_ready) rd_full = 1'b1;
    rd_log.push_back(rd); acc_log.push_back(acc); busy_log.push_back(busy);
    if (acc) got.push_back({bus.out_last, bus.out_data});
    @(posedge clk);
    #1;
    if (rd && fq.size() != 0) void'(fq.pop_front());
    occ_m = occ_m + int'(rd) - int'(acc);
    if (occ_m > occ_max) occ_max = occ_m;
    upd();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_cnt"}, 32'(got.size()), 32'(ex.size()));
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hdead, 32'(ex[i]));
  endtask

  initial begin
    rst = 1'b1; thresh = 4'd4; tmo = 8'd200; flush = 1'b0;
    bus.out_ready = 1'b1; rdy_mode = 0; occ_m = 0;
    upd();
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data), 0);
    chk("rst_last",  32'(bus.out_last), 0);
    chk("rst_rd",    32'(bus.fifo_rd), 0);
    chk("rst_busy",  32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Threshold trigger
    clr(); thresh = 4'd4; tmo = 8'd200;
    for (int i = 0; i < 4; i++) fwr(16'hA000 + 16'(i));
    run(10);
    chk("thr_rd",   pack(rd_log),   32'h03C);
    chk("thr_acc",  pack(acc_log),  32'h078);
    chk("thr_busy", pack(busy_log), 32'h07E);
    ex = '{{1'b0, 16'hA000}, {1'b0, 16'hA001}, {1'b0, 16'hA002}, {1'b1, 16'hA003}};
    chk_words("thr");

    // Timeout: six cycles in WAIT
    clr(); thresh = 4'd8; tmo = 8'd5;
    fwr(16'hB000); fwr(16'hB001);
    run(12);
    chk("tmo_rd",   pack(rd_log),   32'h180);
    chk("tmo_acc",  pack(acc_log),  32'h300);
    chk("tmo_busy", pack(busy_log), 32'h3FE);
    ex = '{{1'b0, 16'hB000}, {1'b1, 16'hB001}};
    chk_words("tmo");

    // Backpressure: out_ready 1,0,0 repeating over an 8-word burst
    clr(); thresh = 4'd8; tmo = 8'd200; rdy_mode = 1;
    for (int i = 0; i < 8; i++) fwr(16'hC000 + 16'(i));
    run(40);
    for (int i = 0; i < 8; i++) ex.push_back({(i == 7), 16'hC000 + 16'(i)});
    chk_words("bp");
    chk("bp_occmax",  32'(occ_max), 2);
    chk("bp_rd_full", 32'(rd_full), 0);
    chk("bp_fifo",    32'(fq.size()), 0);
    chk("bp_busy",    32'(busy), 0);
    rdy_mode = 0;

    // Snapshot: words arriving mid-burst wait for the next burst
    clr(); thresh = 4'd3; tmo = 8'd3;
    for (int i = 0; i < 3; i++) fwr(16'hD000 + 16'(i));
    run(3);
    fwr(16'hD003); fwr(16'hD004);
    run(13);
    chk("snap_rd", pack(rd_log), 32'hC1C);
    ex = '{{1'b0, 16'hD000}, {1'b0, 16'hD001}, {1'b1, 16'hD002},
           {1'b0, 16'hD003}, {1'b1, 16'hD004}};
    chk_words("snap");

    // Zero threshold behaves as one
    clr(); thresh = 4'd0; tmo = 8'd200;
    fwr(16'hE000);
    run(6);
    chk("thr0_rd", pack(rd_log), 32'h004);
    ex = '{{1'b1, 16'hE000}};
    chk_words("thr0");

    // Flush in WAIT overrides a long timeout
    clr(); thresh = 4'd8; tmo = 8'd255;
    fwr(16'hF000);
    run(1);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    run(4);
    chk("fl_rd", pack(rd_log), 32'h004);
    ex = '{{1'b1, 16'hF000}};
    chk_words("fl");

    // Reset mid-burst with both skid entries occupied
    clr(); thresh = 4'd4; tmo = 8'd200; rdy_mode = 2;
    for (int i = 0; i < 4; i++) fwr(16'h9000 + 16'(i));
    run(5);
    chk("mid_occ",   32'(occ_m), 2);
    chk("mid_valid", 32'(bus.out_valid), 1);
    chk("mid_data",  32'(bus.out_data), 32'h9000);
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 0);
    chk("ar_data",  32'(bus.out_data), 0);
    chk("ar_last",  32'(bus.out_last), 0);
    chk("ar_rd",    32'(bus.fifo_rd), 0);
    chk("ar_busy",  32'(busy), 0);
    occ_m = 0; tmo = 8'd2; rdy_mode = 0;
    rst = 1'b0;
    clr();
    run(10);
    chk("rel_rd", pack(rd_log), 32'h030);
    ex = '{{1'b0, 16'h9002}, {1'b1, 16'h9003}};
    chk_words("rel");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
